// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and defaults for the hazard/stall sequencer
package hazard_pkg;

    localparam logic [0:0] S_RUN          = 1'b0;
    localparam logic [0:0] S_BUSY         = 1'b1;
    localparam int         MULDIV_LAT_DEF = 8;
    localparam logic [4:0] REG_ZERO       = 5'd0;

endpackage

// File: rtl/muldiv_occupancy_timer.sv
// rtl/muldiv_occupancy_timer.sv - tracks how long the mult/div unit stays occupied after an issue
module muldiv_occupancy_timer
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Start,
    output logic Busy
);

    localparam logic [7:0] LOAD_VAL = 8'(MULDIV_LAT - 1);

    logic [0:0] r_state;
    logic [7:0] r_md_cnt;

    // Start is only asserted from S_RUN; the top level stalls any issue while busy.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= S_RUN;
            r_md_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (Start) begin
                        r_state  <= S_BUSY;
                        r_md_cnt <= LOAD_VAL;
                    end
                end
                default: begin
                    if (r_md_cnt == 8'd1) begin
                        r_state  <= S_RUN;
                        r_md_cnt <= 8'd0;
                    end else begin
                        r_md_cnt <= r_md_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

    assign Busy = (r_state == S_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / branch-flush / mult-div sequencer for the ID stage
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int MULDIV_LAT = MULDIV_LAT_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             IFID_MulDiv,
    input  logic             IFID_ReadsHiLo,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_RegDst,
    input  logic             EX_BranchTaken,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             MulDiv_Busy,
    output logic             MulDiv_Issue
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      Perf_StallCnt,
    output logic [31:0]      Perf_FlushCnt
`endif
);

    logic w_load_hz;
    logic w_md_hz;
    logic w_stall;
    logic w_busy;
    logic w_issue;

    // $zero is never a real dependency, so a load targeting it cannot cause a stall.
    assign w_load_hz = IDEX_MemRead
                     && (IDEX_RegDst != REG_W'(REG_ZERO))
                     && ((IDEX_RegDst == IFID_Rs) || (IFID_UsesRt && (IDEX_RegDst == IFID_Rt)));
    assign w_md_hz   = w_busy && (IFID_MulDiv || IFID_ReadsHiLo);
    assign w_stall   = (w_load_hz || w_md_hz) && !EX_BranchTaken;
    assign w_issue   = IFID_MulDiv && !w_stall && !EX_BranchTaken;

    muldiv_occupancy_timer #(
        .MULDIV_LAT(MULDIV_LAT)
    ) u_md_timer (
        .Clk  (Clk),
        .Rst  (Rst),
        .Start(w_issue),
        .Busy (w_busy)
    );

    assign PC_Write     = !w_stall;
    assign IFID_Write   = !w_stall;
    assign IDEX_Bubble  = w_stall || EX_BranchTaken;
    assign IFID_Flush   = EX_BranchTaken;
    assign MulDiv_Busy  = w_busy;
    assign MulDiv_Issue = w_issue;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_stall)        r_stall_cnt <= r_stall_cnt + 32'd1;
            if (EX_BranchTaken) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign Perf_StallCnt = r_stall_cnt;
    assign Perf_FlushCnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam int REG_W = 5;
    localparam int LAT   = 8;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic [REG_W-1:0] IFID_Rs = '0;
    logic [REG_W-1:0] IFID_Rt = '0;
    logic             IFID_UsesRt = 1'b0;
    logic             IFID_MulDiv = 1'b0;
    logic             IFID_ReadsHiLo = 1'b0;
    logic             IDEX_MemRead = 1'b0;
    logic [REG_W-1:0] IDEX_RegDst = '0;
    logic             EX_BranchTaken = 1'b0;
    logic             PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, MulDiv_Busy, MulDiv_Issue;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]      Perf_StallCnt, Perf_FlushCnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: remaining busy cycles of the mult/div unit, plus perf tallies.
    int          m_busy_left = 0;
    logic [31:0] m_stall_cnt = 0;
    logic [31:0] m_flush_cnt = 0;

    wire [5:0] obs = {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, MulDiv_Busy, MulDiv_Issue};

    hazard_stall_ctrl #(.REG_W(REG_W), .MULDIV_LAT(LAT)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .IFID_Rs       (IFID_Rs),
        .IFID_Rt       (IFID_Rt),
        .IFID_UsesRt   (IFID_UsesRt),
        .IFID_MulDiv   (IFID_MulDiv),
        .IFID_ReadsHiLo(IFID_ReadsHiLo),
        .IDEX_MemRead  (IDEX_MemRead),
        .IDEX_RegDst   (IDEX_RegDst),
        .EX_BranchTaken(EX_BranchTaken),
        .PC_Write      (PC_Write),
        .IFID_Write    (IFID_Write),
        .IDEX_Bubble   (IDEX_Bubble),
        .IFID_Flush    (IFID_Flush),
        .MulDiv_Busy   (MulDiv_Busy),
        .MulDiv_Issue  (MulDiv_Issue)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .Perf_StallCnt (Perf_StallCnt),
        .Perf_FlushCnt (Perf_FlushCnt)
`endif
    );

    always #5 Clk = ~Clk;

    // Expected {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Busy, Issue} from current inputs.
    function automatic logic [5:0] exp_out();
        logic busy, load_hz, md_hz, stall, issue;
        busy    = (m_busy_left > 0);
        load_hz = IDEX_MemRead && (IDEX_RegDst != 0) &&
                  ((IDEX_RegDst == IFID_Rs) || (IFID_UsesRt && (IDEX_RegDst == IFID_Rt)));
        md_hz   = busy && (IFID_MulDiv || IFID_ReadsHiLo);
        stall   = (load_hz || md_hz) && !EX_BranchTaken;
        issue   = IFID_MulDiv && !stall && !EX_BranchTaken;
        return {!stall, !stall, stall || EX_BranchTaken, EX_BranchTaken, busy, issue};
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic md, input logic hilo, input logic mr,
                         input logic [4:0] dst, input logic br);
        IFID_Rs = rs; IFID_Rt = rt; IFID_UsesRt = uses_rt; IFID_MulDiv = md;
        IFID_ReadsHiLo = hilo; IDEX_MemRead = mr; IDEX_RegDst = dst; EX_BranchTaken = br;
    endtask

    task automatic tick();
        logic [5:0] e;
        e = exp_out();
        @(posedge Clk);
        if (e[0]) m_busy_left = LAT - 1;
        else if (m_busy_left > 0) m_busy_left--;
        if (!e[5]) m_stall_cnt++;
        if (e[2])  m_flush_cnt++;
        #2;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        checks++;
        if (obs !== 6'b110000) begin
            $display("FAIL reset_outputs: got %b want %b", obs, 6'b110000); errors++;
        end
        @(posedge Clk); #2;
        Rst = 1'b0;
        m_busy_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    task automatic test_load_use();
        drive(8, 3, 1, 0, 0, 1, 8, 0);
        #3; checks++;
        if (obs !== 6'b001000) begin
            $display("FAIL load_use_stall: got %b want %b", obs, 6'b001000); errors++;
        end
        tick();
        drive(8, 3, 1, 0, 0, 0, 0, 0);
        #3; checks++;
        if (obs !== 6'b110000) begin
            $display("FAIL load_use_release: got %b want %b", obs, 6'b110000); errors++;
        end
        tick();
    endtask

    task automatic test_no_stall();
        drive(0, 4, 1, 0, 0, 1, 0, 0);
        #3; checks++;
        if (obs !== 6'b110000) begin
            $display("FAIL load_zero_dst: got %b want %b", obs, 6'b110000); errors++;
        end
        tick();
        drive(2, 9, 0, 0, 0, 1, 9, 0);
        #3; checks++;
        if (obs !== 6'b110000) begin
            $display("FAIL load_rt_unused: got %b want %b", obs, 6'b110000); errors++;
        end
        tick();
        drive(2, 9, 1, 0, 0, 1, 9, 0);
        #3; checks++;
        if (obs !== 6'b001000) begin
            $display("FAIL load_rt_used: got %b want %b", obs, 6'b001000); errors++;
        end
        tick();
    endtask

    task automatic test_muldiv();
        drive(1, 2, 1, 1, 0, 0, 0, 0);
        #3; checks++;
        if (obs !== 6'b110001) begin
            $display("FAIL mult_issue: got %b want %b", obs, 6'b110001); errors++;
        end
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        for (int c = 1; c < LAT; c++) begin
            #3; checks++;
            if (obs !== 6'b001010) begin
                $display("FAIL mflo_stall_c%0d: got %b want %b", c, obs, 6'b001010); errors++;
            end
            tick();
        end
        #3; checks++;
        if (obs !== 6'b110000) begin
            $display("FAIL mflo_release: got %b want %b", obs, 6'b110000); errors++;
        end
        tick();
    endtask

    task automatic test_branch_priority();
        drive(8, 0, 0, 1, 0, 1, 8, 1);
        #3; checks++;
        if (obs !== 6'b111100) begin
            $display("FAIL branch_priority: got %b want %b", obs, 6'b111100); errors++;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 2, 1, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        tick(); tick(); tick();
        #1; checks++;
        if (obs !== 6'b001010) begin
            $display("FAIL pre_reset_busy: got %b want %b", obs, 6'b001010); errors++;
        end
        Rst = 1'b1;
        #1; checks++;
        if (obs !== 6'b110000) begin
            $display("FAIL reset_mid_muldiv: got %b want %b", obs, 6'b110000); errors++;
        end
        Rst = 1'b0;
        m_busy_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        #1;
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1, 2, 1, 1, 0, 0, 0, 0);
        tick();
        for (int c = 1; c < LAT; c++) begin
            #3; checks++;
            if (obs !== 6'b001010) begin
                $display("FAIL b2b_stall_c%0d: got %b want %b", c, obs, 6'b001010); errors++;
            end
            tick();
        end
        #3; checks++;
        if (obs !== 6'b110001) begin
            $display("FAIL b2b_second_issue: got %b want %b", obs, 6'b110001); errors++;
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c < LAT; c++) tick();
    endtask

    task automatic test_random();
        logic [5:0] e;
        for (int n = 0; n < 400; n++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                  1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            #3;
            e = exp_out();
            checks++;
            if (obs !== e) begin
                $display("FAIL random_c%0d: got %b want %b", n, obs, e); errors++;
            end
            tick();
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        #3; checks++;
        if (Perf_StallCnt !== m_stall_cnt) begin
            $display("FAIL perf_stall: got %0d want %0d", Perf_StallCnt, m_stall_cnt); errors++;
        end
        checks++;
        if (Perf_FlushCnt !== m_flush_cnt) begin
            $display("FAIL perf_flush: got %0d want %0d", Perf_FlushCnt, m_flush_cnt); errors++;
        end
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_load_use();
        test_no_stall();
        test_muldiv();
        test_branch_priority();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
